// File: rtl/input_debounce_filter_pkg.sv
// Shared sizing constants for the PLC input debounce / snapshot stage.
package input_debounce_filter_pkg;
  localparam int N_CH  = 16;
  localparam int CNT_W = 4;
  localparam int PRE_W = 8;
  localparam int SEL_W = $clog2(N_CH);
endpackage

// File: rtl/input_debounce_filter_channel.sv
// One input channel: 2-flop synchroniser, saturating integrator with hysteresis,
// and rise/fall pulses aligned to the edge where STABLE changes.
module debounce_channel
  import input_debounce_filter_pkg::*;
#(
  parameter int CW = CNT_W
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          raw,
  input  logic          tick,
  input  logic [CW-1:0] filt_len,
  output logic          stable,
  output logic          rise,
  output logic          fall
);
  logic          sync1, s;
  logic [CW-1:0] cnt, cnt_d;
  logic          stable_d;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync1  <= 1'b0;
      s      <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1  <= raw;
      s      <= sync1;
      cnt    <= cnt_d;
      stable <= stable_d;
    end
  end

  always_comb begin
    cnt_d    = cnt;
    stable_d = stable;
    if (tick) begin
      if (filt_len == '0) begin
        cnt_d    = '0;
        stable_d = s;
      end else if (cnt > filt_len) begin
        // threshold lowered under a running count: clamp on a high input
        if (s) begin
          cnt_d    = filt_len;
          stable_d = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end else if (s && (cnt < filt_len)) begin
        cnt_d = cnt + 1'b1;
        if (cnt_d == filt_len) stable_d = 1'b1;
      end else if (!s && (cnt != '0)) begin
        cnt_d = cnt - 1'b1;
        if (cnt_d == '0) stable_d = 1'b0;
      end
    end
  end

  assign rise = stable_d & ~stable;
  assign fall = ~stable_d & stable;
endmodule

// File: rtl/input_debounce_filter.sv
// Debounces N_CH field inputs, freezes a snapshot word on SNAP for serial DMA
// readout via SEL/BIT_OUT, and keeps sticky per-channel edge flags.
module input_debounce_filter
  import input_debounce_filter_pkg::*;
(
  input  logic             CLK,
  input  logic             CLR,
  input  logic [N_CH-1:0]  IN_RAW,
  input  logic [CNT_W-1:0] FILT_LEN,
  input  logic [PRE_W-1:0] PRE_DIV,
  input  logic             SNAP,
  input  logic [SEL_W-1:0] SEL,
  output logic             BIT_OUT,
  output logic [N_CH-1:0]  WORD_OUT,
  output logic [N_CH-1:0]  STABLE,
  output logic [N_CH-1:0]  RISE,
  output logic [N_CH-1:0]  FALL,
  input  logic [N_CH-1:0]  EV_CLR,
  output logic             SNAP_DONE
);
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [N_CH-1:0]  rise_p, fall_p;

  // >= so a runtime PRE_DIV reduction cannot strand the counter above it
  assign tick = (pre_cnt >= PRE_DIV);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) pre_cnt <= '0;
    else      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(.CW(CNT_W)) u_ch (
      .gclk     (CLK),
      .grst_n   (CLR),
      .raw      (IN_RAW[i]),
      .tick     (tick),
      .filt_len (FILT_LEN),
      .stable   (STABLE[i]),
      .rise     (rise_p[i]),
      .fall     (fall_p[i])
    );
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      WORD_OUT  <= '0;
      SNAP_DONE <= 1'b0;
      RISE      <= '0;
      FALL      <= '0;
    end else begin
      if (SNAP) WORD_OUT <= STABLE;
      SNAP_DONE <= SNAP;
      // a new edge in the clear cycle wins over the clear
      RISE <= (RISE & ~EV_CLR) | rise_p;
      FALL <= (FALL & ~EV_CLR) | fall_p;
    end
  end

  assign BIT_OUT = WORD_OUT[SEL];
endmodule

// File: tb/tb_input_debounce_filter.sv
// Scoreboard bench for input_debounce_filter: expectations queued at stimulus time,
// popped and compared when the corresponding output is sampled.
module tb_input_debounce_filter;
  import input_debounce_filter_pkg::*;

  logic             CLK = 1'b0;
  logic             CLR;
  logic [N_CH-1:0]  IN_RAW;
  logic [CNT_W-1:0] FILT_LEN;
  logic [PRE_W-1:0] PRE_DIV;
  logic             SNAP;
  logic [SEL_W-1:0] SEL;
  logic             BIT_OUT;
  logic [N_CH-1:0]  WORD_OUT, STABLE, RISE, FALL, EV_CLR;
  logic             SNAP_DONE;

  always #5 CLK = ~CLK;

  input_debounce_filter dut (
    .CLK(CLK), .CLR(CLR), .IN_RAW(IN_RAW), .FILT_LEN(FILT_LEN), .PRE_DIV(PRE_DIV),
    .SNAP(SNAP), .SEL(SEL), .BIT_OUT(BIT_OUT), .WORD_OUT(WORD_OUT), .STABLE(STABLE),
    .RISE(RISE), .FALL(FALL), .EV_CLR(EV_CLR), .SNAP_DONE(SNAP_DONE)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   done_cnt = 0;

  always @(negedge CLK) if (SNAP_DONE === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL sb_underflow: got %0h, want queued entry", got);
    end else begin
      e = sb.pop_front();
      chk(e.tag, got, e.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [PRE_W-1:0] pre, input logic [CNT_W-1:0] fl);
    CLR = 1'b0; PRE_DIV = pre; FILT_LEN = fl; IN_RAW = '0;
    SNAP = 1'b0; EV_CLR = '0; SEL = '0;
    step(2);
    CLR = 1'b1;
  endtask

  initial begin
    logic [15:0] ref_w;
    logic [5:0]  pat;
    int          base;

    // reset with all inputs high
    CLR = 1'b0; IN_RAW = '1; PRE_DIV = 8'd3; FILT_LEN = '0;
    SNAP = 1'b0; EV_CLR = '0; SEL = '0;
    step(5);
    sb_push("rst_stable", 0); sb_push("rst_word", 0); sb_push("rst_rise", 0);
    sb_push("rst_fall", 0);   sb_push("rst_done", 0); sb_push("rst_bit", 0);
    sb_pop(STABLE); sb_pop(WORD_OUT); sb_pop(RISE); sb_pop(FALL); sb_pop(SNAP_DONE); sb_pop(BIT_OUT);
    CLR = 1'b1;
    sb_push("tick_pre3_e3", 16'h0000); step(3); sb_pop(STABLE);
    sb_push("tick_pre3_e4", 16'hFFFF); step(1); sb_pop(STABLE);
    sb_push("rise_pre3", 16'hFFFF); sb_pop(RISE);
    IN_RAW = '0;
    sb_push("tick_pre3_e7", 16'hFFFF); step(3); sb_pop(STABLE);
    sb_push("tick_pre3_e8", 16'h0000); step(1); sb_pop(STABLE);
    sb_push("fall_pre3", 16'hFFFF); sb_pop(FALL);

    // debounce step, L=4, tick every cycle
    do_reset(8'd0, 4'd4);
    IN_RAW[0] = 1'b1;
    sb_push("deb_e5", 0); step(5); sb_pop(STABLE[0]);
    sb_push("deb_e6", 1); step(1); sb_pop(STABLE[0]);
    sb_push("deb_rise", 1); sb_pop(RISE[0]);

    // 3-cycle glitch never reaches the threshold
    do_reset(8'd0, 4'd4);
    IN_RAW[0] = 1'b1; step(3); IN_RAW[0] = 1'b0;
    sb_push("glitch_stable", 0); sb_push("glitch_rise", 0);
    step(10); sb_pop(STABLE[0]); sb_pop(RISE[0]);

    // hysteresis: 1,1,1,0,1,1 nets to 4 only on the sixth tick
    do_reset(8'd0, 4'd4);
    pat = 6'b110111;
    for (int i = 0; i < 6; i++) begin
      IN_RAW[1] = pat[i];
      step(1);
    end
    sb_push("hyst_5th", 0); step(1); sb_pop(STABLE[1]);
    sb_push("hyst_6th", 1); step(1); sb_pop(STABLE[1]);
    IN_RAW[1] = 1'b0; step(3); IN_RAW[1] = 1'b1;
    sb_push("hyst_hold", 1); sb_push("hyst_nofall", 0);
    step(6); sb_pop(STABLE[1]); sb_pop(FALL[1]);

    // bypass: 2 sync cycles plus one tick
    do_reset(8'd0, 4'd0);
    IN_RAW[2] = 1'b1;
    sb_push("byp_e2", 0); step(2); sb_pop(STABLE[2]);
    sb_push("byp_e3", 1); step(1); sb_pop(STABLE[2]);

    // snapshot coherence and serial readout
    IN_RAW = 16'hA5A5;
    sb_push("snap_pre", 16'hA5A5); step(4); sb_pop(STABLE);
    base = done_cnt;
    SNAP = 1'b1; step(1); SNAP = 1'b0; IN_RAW = '0;
    sb_push("snap_word", 16'hA5A5); sb_push("snap_done_hi", 1);
    sb_pop(WORD_OUT); sb_pop(SNAP_DONE);
    sb_push("snap_done_lo", 0); step(1); sb_pop(SNAP_DONE);
    sb_push("snap_live0", 16'h0000); sb_push("snap_hold", 16'hA5A5);
    step(4); sb_pop(STABLE); sb_pop(WORD_OUT);
    ref_w = 16'hA5A5;
    for (int i = 0; i < N_CH; i++) begin
      SEL = SEL_W'(i);
      sb_push($sformatf("bit_out_%0d", i), ref_w[i]);
      #1 sb_pop(BIT_OUT);
    end
    sb_push("snap_done_once", 1); sb_pop(done_cnt - base);

    // SNAP on the same edge as a STABLE change captures the old value
    IN_RAW = 16'hFFFF; step(2); SNAP = 1'b1; step(1); SNAP = 1'b0;
    sb_push("snap_coinc_word", 16'h0000); sb_push("snap_coinc_live", 16'hFFFF);
    sb_pop(WORD_OUT); sb_pop(STABLE);

    // event flags: set beats a coincident clear
    do_reset(8'd0, 4'd0);
    IN_RAW[3] = 1'b1;
    sb_push("ev_rise", 1); step(3); sb_pop(RISE[3]);
    IN_RAW[3] = 1'b0;
    sb_push("ev_fall", 1); step(3); sb_pop(FALL[3]);
    IN_RAW[3] = 1'b1; step(2); EV_CLR[3] = 1'b1; step(1); EV_CLR = '0;
    sb_push("ev_conf_rise", 1); sb_push("ev_conf_fall", 0);
    sb_pop(RISE[3]); sb_pop(FALL[3]);
    EV_CLR[3] = 1'b1; step(1); EV_CLR = '0;
    sb_push("ev_clr_rise", 0); sb_push("ev_clr_fall", 0);
    sb_pop(RISE[3]); sb_pop(FALL[3]);

    // threshold lowered from 12 to 6 with cnt=10
    do_reset(8'd0, 4'd12);
    IN_RAW[4] = 1'b1;
    sb_push("len_cnt10", 0); step(12); sb_pop(STABLE[4]);
    FILT_LEN = 4'd6;
    sb_push("len_clamp", 1); step(1); sb_pop(STABLE[4]);
    IN_RAW[4] = 1'b0;
    sb_push("len_dec5", 1); step(7); sb_pop(STABLE[4]);
    sb_push("len_dec6", 0); step(1); sb_pop(STABLE[4]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
